// File: rtl/echo_mixer.sv
// echo_mixer: dry/wet gain mix with one shared multiplier, saturation and sticky status
module echo_mixer #(
  parameter int DW = 16,
  parameter int GW = 9,
  parameter int CW = 16
) (
  input  logic          clkMain,
  input  logic          rstMain_n,
  input  logic          sampleTick,
  input  logic [DW-1:0] dryIn,
  input  logic [DW-1:0] wetIn,
  input  logic [GW-1:0] dryGain,
  input  logic [GW-1:0] wetGain,
  input  logic          bypass,
  input  logic          clearFlags,
  output logic [DW-1:0] mixOut,
  output logic          mixValid,
  output logic          busy,
  output logic          clip,
  output logic          overrun,
  output logic [CW-1:0] clipCount
);
  localparam int AW = DW + GW + 1;
  typedef enum logic [1:0] {IDLE, MULD, MULW, SAT} state_t;
  state_t state, state_nx;
  logic [DW-1:0] dry_q, wet_q;
  logic [GW-1:0] dg_q, wg_q;
  logic byp_q;
  logic signed [AW-1:0] acc, mul_a, mul_g, prod;
  logic [AW-9:0] r;
  logic ovf, clip_evt, ovr_evt;
  logic [DW-1:0] sat_val;
  // the single multiplier serves the dry term in MULD and the wet term otherwise
  assign mul_a = state == MULD ? AW'($signed(dry_q)) : AW'($signed(wet_q));
  assign mul_g = state == MULD ? $signed(AW'(dg_q)) : $signed(AW'(wg_q));
  assign prod = mul_a * mul_g;
  // result is out of range when the bits above the output sign disagree
  assign r = acc[AW-1:8];
  assign ovf = ~(&r[AW-9:DW-1] | ~|r[AW-9:DW-1]);
  assign sat_val = byp_q ? dry_q : ovf ? {r[AW-9], {(DW-1){~r[AW-9]}}} : r[DW-1:0];
  assign clip_evt = state == SAT && !byp_q && ovf;
  assign ovr_evt = sampleTick && state != IDLE;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clkMain or negedge rstMain_n) begin
    if (!rstMain_n) state <= IDLE;
    else state <= state_nx;
  end
  // fixed sequence once a tick is accepted
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (sampleTick ? MULD : IDLE) : state == MULD ? MULW : state == MULW ? SAT : IDLE;
  end
  // input latch, accumulator and registered output
  always_ff @(posedge clkMain or negedge rstMain_n) begin
    if (!rstMain_n) begin
      dry_q <= '0;
      wet_q <= '0;
      dg_q <= '0;
      wg_q <= '0;
      byp_q <= 1'b0;
      acc <= '0;
      mixOut <= '0;
      mixValid <= 1'b0;
    end else begin
      if (state == IDLE && sampleTick) begin
        dry_q <= dryIn;
        wet_q <= wetIn;
        dg_q <= dryGain;
        wg_q <= wetGain;
        byp_q <= bypass;
      end
      if (state == MULD) acc <= prod;
      if (state == MULW) acc <= acc + prod;
      if (state == SAT) mixOut <= sat_val;
      mixValid <= state == SAT;
    end
  end
  // sticky status; a same-edge event beats a clear
  always_ff @(posedge clkMain or negedge rstMain_n) begin
    if (!rstMain_n) begin
      clip <= 1'b0;
      overrun <= 1'b0;
      clipCount <= '0;
    end else begin
      clip <= clip_evt | (clip & ~clearFlags);
      overrun <= ovr_evt | (overrun & ~clearFlags);
      clipCount <= clip_evt ? (clearFlags ? CW'(1) : clipCount + CW'(~&clipCount)) : clearFlags ? '0 : clipCount;
    end
  end
endmodule
